// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// The pipeline is frozen while a line is written back to or fetched from off-chip memory.
module dcache_ctrl #(
   parameter int LINES     = 16,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);
   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX - 5;

   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
   state_e state_q, state_d;

   logic [LINE_BITS-1:0] line_q [LINES];
   logic [TAG_W-1:0]     tag_q  [LINES];
   logic [LINES-1:0]     valid_q, dirty_q;
   logic [IDX-1:0]       idx, miss_idx_q;
   logic [TAG_W-1:0]     tag, miss_tag_q;
   logic [2:0]           off;
   logic                 hit, store_hit, fill, addr_unused;

   assign off         = cpu_addr_i[4:2];
   assign idx         = cpu_addr_i[IDX+4:5];
   assign tag         = cpu_addr_i[ADDR_W-1:IDX+5];
   assign addr_unused = ^cpu_addr_i[1:0];
   assign hit         = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
   assign store_hit   = hit & cpu_we_i & (state_q == IDLE);
   assign fill        = (state_q == ALLOCATE) & mem_ack_i;
   assign cpu_stall_o = (cpu_req_i & ~hit) | (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (cpu_req_i && !hit)
                       state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
         ALLOCATE:  if (mem_ack_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      cpu_data_o   = '0;
      case (state_q)
         IDLE: if (hit && !cpu_we_i) cpu_data_o = line_q[idx][{off, 5'b0} +: 32];
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, 5'b0};
            mem_data_o   = line_q[miss_idx_q];
         end
         ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {miss_tag_q, miss_idx_q, 5'b0};
         end
         default: ;
      endcase
   end

   // The miss address is captured so a transfer finishes coherently even if the CPU side moves.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else if (state_q == IDLE && cpu_req_i && !hit) begin
         miss_idx_q <= idx;
         miss_tag_q <= tag;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill) begin
         valid_q[miss_idx_q] <= 1'b1;
         dirty_q[miss_idx_q] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill) begin
         line_q[miss_idx_q] <= mem_data_i;
         tag_q[miss_idx_q]  <= miss_tag_q;
      end else if (store_hit) begin
         line_q[idx][{off, 5'b0} +: 32] <= cpu_data_i;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: golden word memory, line-level backing store and
// a queue of expected memory transfers checked when the responder acks.
module tb_dcache_ctrl;
   logic         clk_i = 1'b0, rst_i = 1'b0;
   logic         cpu_req_i = 1'b0, cpu_we_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0, cpu_data_i = '0, cpu_data_o;
   logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i = 1'b0;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i = '0;

   int errors = 0, checks = 0;
   int wb_lat = 1, al_lat = 1, cyc = 0;
   logic        stray_ack = 1'b0;
   logic [31:0] cur_addr = '0;
   logic        cur_wr = 1'b0;

   typedef struct { logic wr; logic [31:0] addr; } xfer_t;
   xfer_t        xfer_q[$];
   logic [31:0]  exp_q[$];
   logic [31:0]  gold [logic [31:0]];
   logic [255:0] bmem [logic [31:0]];

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
      .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:5], 5'b0};
      return ((base - 32'h400) << 4) | {29'b0, a[4:2]};
   endfunction

   function automatic logic [31:0] gword(input logic [31:0] a);
      if (gold.exists(a)) return gold[a];
      return pat(a);
   endfunction

   function automatic logic [255:0] gline(input logic [31:0] la);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = gword(la + 32'(k*4));
      return l;
   endfunction

   function automatic logic [255:0] bline(input logic [31:0] la);
      logic [255:0] l;
      if (bmem.exists(la)) return bmem[la];
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = pat(la + 32'(k*4));
      return l;
   endfunction

   // Memory responder: acks on the configured cycle of each transfer, checks it against xfer_q.
   always @(negedge clk_i) begin
      xfer_t x;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      if (!rst_i) cyc = 0;
      else if (!mem_enable_o) begin
         cyc = 0;
         mem_ack_i = stray_ack;
      end else begin
         if (cyc == 0 || mem_addr_o != cur_addr || mem_write_o != cur_wr) begin
            cyc = 0; cur_addr = mem_addr_o; cur_wr = mem_write_o;
         end
         cyc++;
         if (cyc == (mem_write_o ? wb_lat : al_lat)) begin
            mem_ack_i = 1'b1;
            cyc = 0;
            if (xfer_q.size() == 0) chk("xfer_unexpected", {mem_write_o, mem_addr_o}, '0);
            else begin
               x = xfer_q.pop_front();
               chk("xfer_wr", mem_write_o, x.wr);
               chk("xfer_addr", mem_addr_o, x.addr);
               if (mem_write_o) begin
                  chk("wb_data", mem_data_o, gline(mem_addr_o));
                  bmem[mem_addr_o] = mem_data_o;
               end else begin
                  chk("fill_data_idle", mem_data_o, '0);
                  mem_data_i = bline(mem_addr_o);
               end
            end
         end
      end
   end

   task automatic push_x(input logic wr, input logic [31:0] a);
      xfer_t x;
      x.wr = wr; x.addr = a;
      xfer_q.push_back(x);
   endtask

   // Called just after a rising edge; leaves just after the edge that completes the access.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input int exp_stall);
      int n = 0;
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_data_i = d;
      if (!we) exp_q.push_back(gword(a));
      #1;
      while (cpu_stall_o && n < 500) begin
         @(posedge clk_i); #1; n++;
      end
      chk("stall_cycles", n, exp_stall);
      if (exp_stall == 0) chk("hit_mem_en", mem_enable_o, 1'b0);
      if (!we) chk("load_data", cpu_data_o, exp_q.pop_front());
      else begin
         chk("store_data_o", cpu_data_o, 32'h0);
         gold[a] = d;
      end
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0;
      chk("xfer_pending", xfer_q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      chk("rst_mem_en", mem_enable_o, 1'b0);
      chk("rst_stall", cpu_stall_o, 1'b0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_data", mem_data_o, '0);
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;

      // 1: cold miss, ack on 10th ALLOCATE cycle
      al_lat = 10; push_x(1'b0, 32'h400);
      access(1'b0, 32'h400, 0, 11);
      // 2: hits
      access(1'b0, 32'h404, 0, 0);
      access(1'b0, 32'h41C, 0, 0);
      // 3: store hit, reload
      access(1'b1, 32'h408, 32'hDEADBEEF, 0);
      access(1'b0, 32'h408, 0, 0);
      // 4: dirty conflict miss
      wb_lat = 1; al_lat = 3; push_x(1'b1, 32'h400); push_x(1'b0, 32'h600);
      access(1'b0, 32'h608, 0, 5);
      // 5: clean store miss, merge, then eviction writes back
      al_lat = 2; push_x(1'b0, 32'h800);
      access(1'b1, 32'h800, 32'h12345678, 3);
      access(1'b0, 32'h800, 0, 0);
      wb_lat = 2; push_x(1'b1, 32'h800); push_x(1'b0, 32'h400);
      access(1'b0, 32'h408, 0, 5);

      // 6: reset mid-ALLOCATE, stray ack while idle
      al_lat = 100;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h424;
      repeat (3) @(posedge clk_i);
      #1 chk("alloc_en", mem_enable_o, 1'b1);
      rst_i = 1'b0;
      #1;
      chk("rst_mid_en", mem_enable_o, 1'b0);
      chk("rst_mid_wr", mem_write_o, 1'b0);
      chk("rst_mid_stall", cpu_stall_o, 1'b1);
      cpu_req_i = 1'b0;
      #1 chk("rst_noreq_stall", cpu_stall_o, 1'b0);
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1 stray_ack = 1'b1;
      @(posedge clk_i); #1 stray_ack = 1'b0;
      chk("stray_en", mem_enable_o, 1'b0);
      chk("stray_stall", cpu_stall_o, 1'b0);
      al_lat = 4; push_x(1'b0, 32'h400);
      access(1'b0, 32'h404, 0, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
